common_cross_buffer_n: RTL and testbench
========================================

Name: common_cross_buffer_n

Overview:
- Parametrised N-to-1 merge buffer; successor of the 2-input cross buffer.
- Arbitrates CHANNEL_COUNT valid/ready producers onto one valid/ready consumer through a BUFFER_DEPTH-entry FIFO.
- Output carries source channel index alongside data.
- Sits at any many-producer/one-consumer junction, e.g. multiple issue lanes merging into one writeback port.

Parameters:
- BUFFER_WIDTH, 32, payload width in bits.
- CHANNEL_COUNT, 4, number of input channels (2..16).
- BUFFER_DEPTH, 2, FIFO entries; power of two, >=2.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- Derived constants: CH_W = max(1, clog2(CHANNEL_COUNT)); PTR_W = clog2(BUFFER_DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- prev_i_data  in  CHANNEL_COUNT*BUFFER_WIDTH  channel i occupies bits [i*BUFFER_WIDTH +: BUFFER_WIDTH].
- prev_i_valid  in  CHANNEL_COUNT  per-channel valid.
- prev_o_ready  out  CHANNEL_COUNT  per-channel ready; one-hot or zero.
- next_o_data  out  BUFFER_WIDTH  head-of-FIFO payload.
- next_o_source  out  CH_W  channel index of the head entry.
- next_o_valid  out  1  FIFO non-empty.
- next_i_ready  in  1  consumer ready.
- o_count  out  PTR_W+1  current occupancy, 0..BUFFER_DEPTH.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - count, rd_ptr, wr_ptr and the round-robin pointer rr_ptr clear to 0.
  - Storage clears to 0.
  - While resetn=0: next_o_valid=0, prev_o_ready=0, next_o_data=0, next_o_source=0, o_count=0.
  - Reset mid-operation discards all buffered entries; nothing buffered is emitted after reset.
- Arbitration (combinational):
  - Candidate set = prev_i_valid, masked to all zeros when count == BUFFER_DEPTH.
  - ARB_MODE=0: the first set bit scanning from rr_ptr upward, wrapping at CHANNEL_COUNT-1 to 0, is granted.
  - ARB_MODE=1: the lowest set bit is granted.
  - prev_o_ready = grant vector. At most one bit is set. Ready is never asserted toward a channel whose valid is low.
- Ready path:
  - prev_o_ready depends only on registered count and prev_i_valid.
  - There is no combinational path from next_i_ready to prev_o_ready.
  - When full, inputs stall even if a pop occurs in the same cycle.
- Push (grant nonzero at the edge):
  - Writes {index, data} of the granted channel at wr_ptr; wr_ptr increments with wrap.
  - In round-robin mode, rr_ptr becomes (granted index + 1) mod CHANNEL_COUNT. rr_ptr is unchanged when there is no grant, and is unused in fixed mode.
- Pop (next_o_valid && next_i_ready at the edge): rd_ptr increments with wrap.
- Count:
  - Push only: +1. Pop only: -1. Simultaneous push and pop: unchanged.
  - Overflow and underflow are impossible by construction; the bench asserts this.
- Output:
  - next_o_valid = (count != 0); next_o_data/next_o_source = entry at rd_ptr (registered storage).
  - Latency: a channel accepted at edge t is presented valid after edge t, i.e. 1 cycle, provided the FIFO was empty.
- Protocol:
  - Producers must hold valid/data stable until accepted.
  - Output is stable while next_o_valid=1 && next_i_ready=0.
- Ordering:
  - Entries are emitted in acceptance order.
  - Per-channel order is preserved.
- Throughput: 1 accept and 1 emit per cycle at steady state when count < BUFFER_DEPTH.
- Fairness (ARB_MODE=0): with all channels continuously valid, grants cycle 0,1,...,N-1,0; no channel waits more than CHANNEL_COUNT-1 grants.

Decomposition:
- Package common_cross_buffer_pkg holds:
  - ARB_RR / ARB_FIXED constants.
  - A clog2 helper function for CH_W and PTR_W.
- Sub-module common_rr_arbiter: inputs request vector, rr_ptr and mode; outputs a one-hot grant and a binary index. It is reused by other merge blocks.
- FIFO storage and pointers stay inline.

Test Plan (defaults: W=32, N=4, DEPTH=2, RR):
- Reset: hold resetn=0 for 3 cycles with all channels valid -> prev_o_ready=0000, next_o_valid=0, o_count=0 throughout; first grant after release goes to channel 0.
- Single push, 1-cycle latency: ch2 valid with 0xDEADBEEF, next_i_ready=1 -> ready[2] at t0; next_o_valid=1, data=0xDEADBEEF, source=2 at t1; o_count returns to 0 at t2.
- Round-robin fairness: all 4 channels valid with data 0x10+i, next_i_ready=1 -> output sources 0,1,2,3,0,1 in order, one per cycle, no bubbles.
- Full/stall: next_i_ready=0 with ch0 and ch1 valid -> accepts 2 entries, o_count=2, prev_o_ready=0000. Raise next_i_ready -> first cycle pops with no accept (o_count=1), then push and pop alternate with o_count steady at 1.
- Fixed priority (ARB_MODE=1): ch1 and ch3 continuously valid -> only ch1 is granted until ch1 valid drops, then ch3 is granted the next cycle.
- Reset mid-operation: FIFO holds 2 entries, pulse resetn=0 for 1 cycle -> next_o_valid=0 the next cycle; the old entries never appear.

Source files
------------

// File: rtl/common_cross_buffer_pkg.sv
// Shared definitions for the N-to-1 cross buffer family.
//   arb_mode_e : arbitration policy selector (round-robin / fixed priority)
//   clog2      : ceiling log2 for elaboration-time width derivation
//   ch_width   : channel index width, never narrower than one bit
package common_cross_buffer_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

  function automatic int unsigned ch_width(input int unsigned count);
    int unsigned w;
    w = clog2(count);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/common_rr_arbiter.sv
// Request arbiter shared by the merge blocks.
//   req         : request vector, one bit per channel
//   rr_ptr      : round-robin start position (ignored in fixed mode)
//   mode        : ARB_RR scans upward from rr_ptr with wrap,
//                 ARB_FIXED grants the lowest set request
//   grant       : one-hot grant, zero when no request
//   grant_idx   : binary index of the granted channel
//   grant_valid : any grant issued
module common_rr_arbiter
  import common_cross_buffer_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = ch_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  arb_mode_e        mode,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  int unsigned      start;
  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    start       = 0;
    // An out-of-range pointer (only possible for non-power-of-two N)
    // falls back to scanning from channel 0.
    if (mode == ARB_RR && 32'(rr_ptr) < N) begin
      start = 32'(rr_ptr);
    end
    for (int unsigned off = 0; off < N; off++) begin
      cand = start + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_valid && req[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/common_cross_buffer_n.sv
// N-to-1 merge buffer: arbitrates CHANNEL_COUNT valid/ready producers
// into a BUFFER_DEPTH-entry FIFO drained by one valid/ready consumer.
// Each entry carries the source channel index next to its payload.
//   clk, resetn   : clock, synchronous active-low reset
//   prev_i_data   : packed channel payloads, channel i at [i*W +: W]
//   prev_i_valid  : per-channel valid
//   prev_o_ready  : per-channel ready (the grant), one-hot or zero
//   next_o_data   : head-of-FIFO payload
//   next_o_source : head-of-FIFO source channel
//   next_o_valid  : FIFO non-empty
//   next_i_ready  : consumer ready
//   o_count       : current occupancy
module common_cross_buffer_n
  import common_cross_buffer_pkg::*;
#(
  parameter  int unsigned BUFFER_WIDTH  = 32,
  parameter  int unsigned CHANNEL_COUNT = 4,
  parameter  int unsigned BUFFER_DEPTH  = 2,
  parameter  int unsigned ARB_MODE      = 0,
  localparam int unsigned CH_W          = ch_width(CHANNEL_COUNT),
  localparam int unsigned PTR_W         = clog2(BUFFER_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [CHANNEL_COUNT*BUFFER_WIDTH-1:0] prev_i_data,
  input  logic [CHANNEL_COUNT-1:0]              prev_i_valid,
  output logic [CHANNEL_COUNT-1:0]              prev_o_ready,
  output logic [BUFFER_WIDTH-1:0]               next_o_data,
  output logic [CH_W-1:0]                       next_o_source,
  output logic                                  next_o_valid,
  input  logic                                  next_i_ready,
  output logic [PTR_W:0]                        o_count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(BUFFER_DEPTH);
  localparam arb_mode_e      MODE       = (ARB_MODE == 1) ? ARB_FIXED : ARB_RR;
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(CHANNEL_COUNT - 1);

  logic [BUFFER_WIDTH-1:0] mem_data [BUFFER_DEPTH];
  logic [CH_W-1:0]         mem_src  [BUFFER_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  rr_next;

  logic                     full;
  logic                     push;
  logic                     pop;
  logic [CHANNEL_COUNT-1:0] req;
  logic [CHANNEL_COUNT-1:0] grant;
  logic [CH_W-1:0]          grant_idx;
  logic                     grant_valid;
  logic [BUFFER_WIDTH-1:0]  push_data;

  // Requests are masked on the registered count only, so a pop in the
  // same cycle never opens the input side: no next_i_ready -> ready path.
  assign full = (count == FULL_COUNT);
  assign req  = full ? '0 : prev_i_valid;

  common_rr_arbiter #(
    .N     (CHANNEL_COUNT),
    .IDX_W (CH_W)
  ) u_arb (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .mode        (MODE),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign push = grant_valid;
  assign pop  = (count != '0) && next_i_ready;

  always_comb begin
    push_data = '0;
    for (int unsigned i = 0; i < CHANNEL_COUNT; i++) begin
      if (grant[i]) begin
        push_data = prev_i_data[i*BUFFER_WIDTH +: BUFFER_WIDTH];
      end
    end
  end

  always_comb begin
    rr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rr_ptr   <= '0;
      mem_data <= '{default: '0};
      mem_src  <= '{default: '0};
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_src[wr_ptr]  <= grant_idx;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        if (MODE == ARB_RR) begin
          rr_ptr <= rr_next;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, including before the
  // first reset edge has cleared the registers.
  assign prev_o_ready  = resetn ? grant : '0;
  assign next_o_valid  = resetn && (count != '0);
  assign next_o_data   = resetn ? mem_data[rd_ptr] : '0;
  assign next_o_source = resetn ? mem_src[rd_ptr] : '0;
  assign o_count       = resetn ? count : '0;

endmodule

// File: tb/tb_common_cross_buffer_n.sv
module tb_common_cross_buffer_n;

  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  // index 0: round-robin DUT, index 1: fixed-priority DUT
  logic [N*W-1:0] pdata  [2];
  logic [N-1:0]   pvalid [2];
  logic           nrdy   [2];
  logic [N-1:0]   pready [2];
  logic [W-1:0]   ndata  [2];
  logic [1:0]     nsrc   [2];
  logic           nvalid [2];
  logic [1:0]     ocount [2];

  always #5 clk = ~clk;

  common_cross_buffer_n #(
    .BUFFER_WIDTH  (W),
    .CHANNEL_COUNT (N),
    .BUFFER_DEPTH  (D),
    .ARB_MODE      (0)
  ) u_rr (
    .clk           (clk),
    .resetn        (resetn),
    .prev_i_data   (pdata[0]),
    .prev_i_valid  (pvalid[0]),
    .prev_o_ready  (pready[0]),
    .next_o_data   (ndata[0]),
    .next_o_source (nsrc[0]),
    .next_o_valid  (nvalid[0]),
    .next_i_ready  (nrdy[0]),
    .o_count       (ocount[0])
  );

  common_cross_buffer_n #(
    .BUFFER_WIDTH  (W),
    .CHANNEL_COUNT (N),
    .BUFFER_DEPTH  (D),
    .ARB_MODE      (1)
  ) u_fx (
    .clk           (clk),
    .resetn        (resetn),
    .prev_i_data   (pdata[1]),
    .prev_i_valid  (pvalid[1]),
    .prev_o_ready  (pready[1]),
    .next_o_data   (ndata[1]),
    .next_o_source (nsrc[1]),
    .next_o_valid  (nvalid[1]),
    .next_i_ready  (nrdy[1]),
    .o_count       (ocount[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int           src;
    logic [W-1:0] data;
  } ent_t;

  typedef struct {
    int           src;
    logic [W-1:0] data;
    int           cyc;
  } log_t;

  ent_t q0[$];
  ent_t q1[$];
  int   rr [2] = '{0, 0};
  logic [N-1:0] acc [2] = '{'0, '0};
  log_t elog[$];
  logic log_en = 1'b0;
  int   cyc = 0;

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ent_t qhead(input int d);
    ent_t e;
    e.src  = 0;
    e.data = '0;
    if (d == 0 && q0.size() != 0) e = q0[0];
    if (d == 1 && q1.size() != 0) e = q1[0];
    return e;
  endfunction

  task automatic qpop(input int d);
    if (d == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int d, input ent_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic qclear(input int d);
    if (d == 0) q0.delete();
    else        q1.delete();
  endtask

  // DUT 0 scans from its rotating pointer, DUT 1 takes the lowest index
  function automatic int pick(input int d, input logic [N-1:0] v);
    int i;
    for (int off = 0; off < N; off++) begin
      i = (d == 0) ? (rr[d] + off) % N : off;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  int           m_sz;
  int           m_g;
  logic [N-1:0] m_eg;
  ent_t         m_h;
  ent_t         m_new;
  log_t         m_log;

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      m_sz = qsize(d);
      m_h  = qhead(d);
      m_g  = -1;
      m_eg = '0;
      if (resetn && m_sz < D) m_g = pick(d, pvalid[d]);
      if (m_g >= 0) m_eg[m_g] = 1'b1;

      chk($sformatf("ready[%0d]", d), pready[d], m_eg);
      chk($sformatf("valid[%0d]", d), nvalid[d], resetn && m_sz != 0);
      chk($sformatf("count[%0d]", d), ocount[d], resetn ? m_sz : 0);
      chk($sformatf("no_overflow[%0d]", d), ocount[d] <= D, 1);
      if (!resetn) begin
        chk($sformatf("rst_data[%0d]", d), ndata[d], 0);
        chk($sformatf("rst_src[%0d]", d), nsrc[d], 0);
      end else if (m_sz != 0) begin
        chk($sformatf("data[%0d]", d), ndata[d], m_h.data);
        chk($sformatf("src[%0d]", d), nsrc[d], m_h.src);
      end

      if (!resetn) begin
        qclear(d);
        rr[d]  = 0;
        acc[d] = '0;
      end else begin
        if (m_sz != 0 && nrdy[d]) begin
          if (d == 0 && log_en) begin
            m_log.src  = m_h.src;
            m_log.data = m_h.data;
            m_log.cyc  = cyc;
            elog.push_back(m_log);
          end
          qpop(d);
        end
        if (m_g >= 0) begin
          m_new.src  = m_g;
          m_new.data = pdata[d][m_g*W +: W];
          qpush(d, m_new);
          if (d == 0) rr[d] = (m_g + 1) % N;
        end
        acc[d] = m_eg;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic setch(input int d, input int ch, input logic v, input logic [W-1:0] dat);
    pvalid[d][ch] = v;
    pdata[d][ch*W +: W] = dat;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pdata[d]  = '0;
      pvalid[d] = '0;
      nrdy[d]   = 1'b1;
    end
    resetn = 1'b0;

    // reset held with every channel requesting
    for (int ch = 0; ch < N; ch++) setch(0, ch, 1'b1, 32'h10 + ch);
    repeat (3) begin
      tick();
      #1;
      chk("rst_ready", pready[0], 4'b0000);
      chk("rst_valid", nvalid[0], 0);
      chk("rst_count", ocount[0], 0);
    end

    // release: first grant to ch0, then fair rotation with no bubbles
    elog.delete();
    log_en = 1'b1;
    resetn = 1'b1;
    #1;
    chk("first_grant", pready[0], 4'b0001);
    repeat (9) tick();
    chk("fair_len", elog.size() >= 6, 1);
    for (int k = 0; k < 6 && k < elog.size(); k++) begin
      chk("fair_src", elog[k].src, k % 4);
      chk("fair_data", elog[k].data, 32'h10 + (k % 4));
      chk("fair_gap", elog[k].cyc - elog[0].cyc, k);
    end
    log_en = 1'b0;
    for (int ch = 0; ch < N; ch++) setch(0, ch, 1'b0, '0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;

    // single push, one-cycle latency
    setch(0, 2, 1'b1, 32'hDEADBEEF);
    #1;
    chk("sp_ready_t0", pready[0], 4'b0100);
    chk("sp_valid_t0", nvalid[0], 0);
    tick();
    setch(0, 2, 1'b0, '0);
    #1;
    chk("sp_valid_t1", nvalid[0], 1);
    chk("sp_data_t1", ndata[0], 32'hDEADBEEF);
    chk("sp_src_t1", nsrc[0], 2);
    chk("sp_count_t1", ocount[0], 1);
    tick();
    #1;
    chk("sp_count_t2", ocount[0], 0);
    chk("sp_valid_t2", nvalid[0], 0);

    // full / stall (rr pointer now 3)
    nrdy[0] = 1'b0;
    setch(0, 0, 1'b1, 32'hA0);
    setch(0, 1, 1'b1, 32'hA1);
    #1;
    chk("fs_ready0", pready[0], 4'b0001);
    tick(); #1;
    chk("fs_ready1", pready[0], 4'b0010);
    chk("fs_count1", ocount[0], 1);
    tick(); #1;
    chk("fs_ready_full", pready[0], 4'b0000);
    chk("fs_count_full", ocount[0], 2);
    tick(); #1;
    chk("fs_hold_count", ocount[0], 2);
    chk("fs_hold_src", nsrc[0], 0);
    chk("fs_hold_data", ndata[0], 32'hA0);
    nrdy[0] = 1'b1;
    #1;
    chk("fs_stall_on_pop", pready[0], 4'b0000);
    tick(); #1;
    chk("fs_after_pop_count", ocount[0], 1);
    chk("fs_after_pop_ready", pready[0], 4'b0001);
    chk("fs_after_pop_src", nsrc[0], 1);
    tick(); #1;
    chk("fs_steady_count_a", ocount[0], 1);
    chk("fs_steady_ready_a", pready[0], 4'b0010);
    chk("fs_steady_src_a", nsrc[0], 0);
    tick(); #1;
    chk("fs_steady_count_b", ocount[0], 1);
    chk("fs_steady_ready_b", pready[0], 4'b0001);
    chk("fs_steady_src_b", nsrc[0], 1);
    setch(0, 0, 1'b0, '0);
    setch(0, 1, 1'b0, '0);
    repeat (3) tick();

    // fixed priority on the second DUT
    setch(1, 1, 1'b1, 32'hB1);
    setch(1, 3, 1'b1, 32'hB3);
    repeat (4) begin
      #1;
      chk("fx_ch1", pready[1], 4'b0010);
      tick();
    end
    setch(1, 1, 1'b0, '0);
    #1;
    chk("fx_ch3", pready[1], 4'b1000);
    tick();
    setch(1, 3, 1'b0, '0);
    #1;
    chk("fx_src3", nsrc[1], 3);
    chk("fx_data3", ndata[1], 32'hB3);
    tick();

    // reset mid-operation with two entries buffered
    nrdy[0] = 1'b0;
    setch(0, 0, 1'b1, 32'hAAAA0000);
    setch(0, 1, 1'b1, 32'hBBBB0001);
    tick();
    tick();
    setch(0, 0, 1'b0, '0);
    setch(0, 1, 1'b0, '0);
    #1;
    chk("mr_count_before", ocount[0], 2);
    resetn = 1'b0;
    #1;
    chk("mr_valid_during", nvalid[0], 0);
    tick();
    resetn = 1'b1;
    #1;
    chk("mr_valid_after", nvalid[0], 0);
    chk("mr_count_after", ocount[0], 0);
    nrdy[0] = 1'b1;
    elog.delete();
    log_en = 1'b1;
    repeat (4) tick();
    #1;
    chk("mr_valid_late", nvalid[0], 0);
    chk("mr_no_old", elog.size(), 0);
    log_en = 1'b0;

    // randomized traffic; producers hold until accepted
    repeat (3000) begin
      tick();
      resetn = ($urandom_range(0, 299) != 0);
      for (int d = 0; d < 2; d++) begin
        nrdy[d] = ($urandom_range(0, 9) < 7);
        for (int ch = 0; ch < N; ch++) begin
          if (!pvalid[d][ch] || acc[d][ch]) begin
            setch(d, ch, 1'($urandom_range(0, 1)), $urandom);
          end
        end
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
